// File: rtl/tx_alc.sv
// Transmit automatic level control: scales x_in by a Q2.14 gain and adapts the
// gain once per measurement window so the mean output power tracks target^2.
module tx_alc #(
   parameter logic [15:0] GAIN_INIT = 16'h4000,
   parameter int          LOCK_CNT  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               in_valid,
   input  logic signed [15:0] x_in,
   input  logic        [15:0] target,
   input  logic        [3:0]  win_log2,
   input  logic        [7:0]  step,
   input  logic        [15:0] gain_min,
   input  logic        [15:0] gain_max,
   output logic signed [15:0] y_out,
   output logic               out_valid,
   output logic        [15:0] gain,
   output logic               gain_upd,
   output logic               sat,
   output logic               locked
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;
   localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);

   logic [1:0]  state_reg;
   logic [15:0] gain_reg;
   logic [43:0] acc_reg;
   logic [12:0] cnt_reg;
   logic [3:0]  w_reg;
   logic [7:0]  tol_reg;

   // ---------------- datapath ----------------
   logic signed [32:0] prod;
   logic signed [18:0] prod_sh;
   logic               sat_c;
   logic signed [15:0] y_c;

   assign prod    = 33'($signed({1'b0, gain_reg})) * 33'(x_in);
   assign prod_sh = prod[32:14];
   assign sat_c   = (prod_sh > 19'sd32767) || (prod_sh < -19'sd32768);
   assign y_c     = sat_c ? (prod_sh[18] ? 16'sh8000 : 16'sh7FFF) : prod_sh[15:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_out     <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         sat       <= in_valid & sat_c;
         if (in_valid) y_out <= y_c;
      end
   end

   // ---------------- loop arithmetic ----------------
   logic        [3:0]  w_clamped;
   logic        [12:0] win_len;
   logic        [12:0] cnt_inc;
   logic signed [31:0] sq;
   logic        [43:0] acc_add;
   logic        [31:0] tp;
   logic        [43:0] mean_full;
   logic signed [32:0] err;
   logic signed [20:0] err_sh;
   logic signed [29:0] dprod;
   logic signed [21:0] delta;
   logic signed [23:0] gsum;
   logic        [32:0] abs_err;
   logic               in_tol;
   logic        [15:0] g_new;

   assign w_clamped = (win_log2 < 4'd4) ? 4'd4 : ((win_log2 > 4'd12) ? 4'd12 : win_log2);
   assign win_len   = 13'd1 << w_reg;
   assign cnt_inc   = cnt_reg + 13'd1;
   assign sq        = 32'(y_out) * 32'(y_out);
   assign acc_add   = acc_reg + {12'b0, sq};
   assign tp        = 32'(target) * 32'(target);
   assign mean_full = acc_reg >> w_reg;
   // Mean power is at most 2^30, so the low 32 bits of the mean are exact.
   assign err       = $signed({1'b0, tp}) - $signed({1'b0, mean_full[31:0]});
   assign err_sh    = err[32:12];
   assign dprod     = 30'(err_sh) * 30'($signed({1'b0, step}));
   assign delta     = dprod[29:8];
   assign gsum      = $signed({8'b0, gain_reg}) + $signed({{2{delta[21]}}, delta});
   assign abs_err   = err[32] ? -err : err;
   assign in_tol    = abs_err <= {5'b0, tp[31:4]};

   always_comb begin
      g_new = gsum[15:0];
      if (gain_min > gain_max)
         g_new = gain_max;
      else if (gsum < $signed({8'b0, gain_min}))
         g_new = gain_min;
      else if (gsum > $signed({8'b0, gain_max}))
         g_new = gain_max;
   end

   logic unused_bits;
   assign unused_bits = ^{prod[13:0], mean_full[43:32], err[11:0], dprod[7:0], tp[3:0]};

   // ---------------- control ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         gain_reg  <= GAIN_INIT;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         w_reg     <= 4'd4;
         tol_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               acc_reg <= '0;
               cnt_reg <= '0;
               tol_reg <= '0;
               if (enable) begin
                  state_reg <= ACCUM;
                  w_reg     <= w_clamped;
               end
            end
            ACCUM: begin
               if (!enable) begin
                  state_reg <= IDLE;
               end else if (out_valid) begin
                  acc_reg <= acc_add;
                  cnt_reg <= cnt_inc;
                  if (cnt_inc == win_len) state_reg <= UPDATE;
               end
            end
            UPDATE: begin
               if (!enable) begin
                  state_reg <= IDLE;
               end else begin
                  gain_reg  <= g_new;
                  state_reg <= ACCUM;
                  w_reg     <= w_clamped;
                  // A sample landing in this cycle opens the next window.
                  acc_reg   <= out_valid ? {12'b0, sq} : 44'd0;
                  cnt_reg   <= out_valid ? 13'd1 : 13'd0;
                  if (!in_tol)
                     tol_reg <= '0;
                  else if (tol_reg < LOCK_N)
                     tol_reg <= tol_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gain     = gain_reg;
   assign gain_upd = (state_reg == UPDATE) && enable;
   assign locked   = (state_reg != IDLE) && (tol_reg >= LOCK_N);

endmodule
